// File: rtl/sensor_debounce_pkg.sv
// Shared definitions for the Monitor pin-conditioning blocks: board-clock
// default debounce window, default widths and the edge-pulse encoding.
package sensor_debounce_pkg;

  // 1 ms at the 50 MHz board clock.
  localparam int DEF_STABLE_CYCLES = 50000;
  localparam int DEF_CNT_W         = 16;
  localparam int DEF_EVT_W         = 16;

  // Which pulse, if any, the debouncer emits on the next edge.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous pin; resets both flops to
// RESET_LEVEL so the downstream logic sees a defined level during reset.
module sync_2ff #(
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  // Metastability filter: d -> s1 -> q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RESET_LEVEL;
      q  <= RESET_LEVEL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/sensor_debounce.sv
// Debounces one raw sensor/button pin: synchronizes it, accepts a new level
// only after it has held for STABLE_CYCLES consecutive cycles, and emits
// registered one-cycle rise/fall pulses aligned with the new level.
// Optional accepted-rise counter enabled by defining SENSOR_EVT_CNT_EN.
module sensor_debounce
  import sensor_debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int   CNT_W         = DEF_CNT_W,
  parameter logic RESET_LEVEL   = 1'b0,
  parameter int   EVT_W         = DEF_EVT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level,
  output logic rise,
  output logic fall
`ifdef SENSOR_EVT_CNT_EN
  ,
  input  logic             evt_clr,
  output logic [EVT_W-1:0] event_count
`endif
);

  // Reject parameter sets the counter cannot represent.
  if (STABLE_CYCLES < 1 || EVT_W < 1 || (2.0 ** CNT_W) <= (STABLE_CYCLES - 1)) begin : g_param_check
    $error("sensor_debounce: illegal STABLE_CYCLES/CNT_W/EVT_W combination");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_nxt;
  edge_e            edge_nxt;

  sync_2ff #(
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (raw_in),
    .q     (s)
  );

  // Qualification: any agreeing sample restarts the count from zero.
  always_comb begin
    cnt_nxt   = '0;
    level_nxt = level;
    edge_nxt  = EDGE_NONE;
    if (s != level) begin
      if (cnt == CNT_LAST) begin
        level_nxt = s;
        edge_nxt  = s ? EDGE_RISE : EDGE_FALL;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  // Level, counter and edge pulses; pulses appear with the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= RESET_LEVEL;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      level <= level_nxt;
      cnt   <= cnt_nxt;
      rise  <= (edge_nxt == EDGE_RISE);
      fall  <= (edge_nxt == EDGE_FALL);
    end
  end

`ifdef SENSOR_EVT_CNT_EN
  // Counts rise pulses, wrapping naturally; a clear beats a coincident rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_count <= '0;
    end else if (evt_clr) begin
      event_count <= '0;
    end else if (rise) begin
      event_count <= event_count + EVT_W'(1);
    end
  end
`endif

endmodule
